// File: rtl/mips_pkg.sv
// Shared constants and types for the 16-bit MIPS pipeline: widths, aluOp classes, funct codes,
// the internal ALU operation enum, and the aluOp/funct to ALU operation decode.
package mips_pkg;
  localparam int DW = 16;
  localparam int RW = 3;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [2:0] FUNCT_ADD = 3'b000;
  localparam logic [2:0] FUNCT_SUB = 3'b001;
  localparam logic [2:0] FUNCT_AND = 3'b010;
  localparam logic [2:0] FUNCT_OR  = 3'b011;
  localparam logic [2:0] FUNCT_SLT = 3'b100;
  localparam logic [2:0] FUNCT_NOR = 3'b101;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_NOR
  } alu_op_e;

  // Unused funct codes fall back to ADD.
  function automatic alu_op_e decode_alu(input logic [1:0] alu_op, input logic [2:0] funct);
    alu_op_e op;
    op = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: op = ALU_ADD;
      ALUOP_SUB: op = ALU_SUB;
      ALUOP_OR:  op = ALU_OR;
      default: begin
        case (funct)
          FUNCT_SUB: op = ALU_SUB;
          FUNCT_AND: op = ALU_AND;
          FUNCT_OR:  op = ALU_OR;
          FUNCT_SLT: op = ALU_SLT;
          FUNCT_NOR: op = ALU_NOR;
          default:   op = ALU_ADD;
        endcase
      end
    endcase
    return op;
  endfunction
endpackage

// File: rtl/ex_mem_stage_if.sv
// ID/EX input bundle, MEM/WB write-back bundle, stage control and EX/MEM output bundle.
// The master modport is the pipeline side that drives ID/EX; the slave modport is the EX stage.
interface ex_mem_stage_if;
  import mips_pkg::*;

  logic          en;
  logic          flush;
  logic          regDst_out_pipe_2;
  logic          aluSrc_out_pipe_2;
  logic          memtoReg_out_pipe_2;
  logic          regWrite_out_pipe_2;
  logic          memRead_out_pipe_2;
  logic          memWrite_out_pipe_2;
  logic          branch_out_pipe_2;
  logic [1:0]    aluOp_out_pipe_2;
  logic [DW-1:0] sign_extended_imm_out_pipe_2;
  logic [DW-1:0] read_data_1_out_pipe_2;
  logic [DW-1:0] read_data_2_out_pipe_2;
  logic [DW-1:0] pc_plus_2_out_pipe_2;
  logic [RW-1:0] rd_out_pipe_2;
  logic [RW-1:0] rt_out_pipe_2;
  logic [RW-1:0] rs_out_pipe_2;
  logic          wb_regWrite;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;

  logic [DW-1:0] alu_result_out_pipe_3;
  logic [DW-1:0] write_data_out_pipe_3;
  logic [DW-1:0] branch_target_out_pipe_3;
  logic [RW-1:0] dest_out_pipe_3;
  logic          regWrite_out_pipe_3;
  logic          memtoReg_out_pipe_3;
  logic          memRead_out_pipe_3;
  logic          memWrite_out_pipe_3;
  logic          branch_taken_out_pipe_3;
  logic          zero_out_pipe_3;

  modport master (
    output en, flush, regDst_out_pipe_2, aluSrc_out_pipe_2, memtoReg_out_pipe_2,
           regWrite_out_pipe_2, memRead_out_pipe_2, memWrite_out_pipe_2, branch_out_pipe_2,
           aluOp_out_pipe_2, sign_extended_imm_out_pipe_2, read_data_1_out_pipe_2,
           read_data_2_out_pipe_2, pc_plus_2_out_pipe_2, rd_out_pipe_2, rt_out_pipe_2,
           rs_out_pipe_2, wb_regWrite, wb_rd, wb_data,
    input  alu_result_out_pipe_3, write_data_out_pipe_3, branch_target_out_pipe_3,
           dest_out_pipe_3, regWrite_out_pipe_3, memtoReg_out_pipe_3, memRead_out_pipe_3,
           memWrite_out_pipe_3, branch_taken_out_pipe_3, zero_out_pipe_3
  );

  modport slave (
    input  en, flush, regDst_out_pipe_2, aluSrc_out_pipe_2, memtoReg_out_pipe_2,
           regWrite_out_pipe_2, memRead_out_pipe_2, memWrite_out_pipe_2, branch_out_pipe_2,
           aluOp_out_pipe_2, sign_extended_imm_out_pipe_2, read_data_1_out_pipe_2,
           read_data_2_out_pipe_2, pc_plus_2_out_pipe_2, rd_out_pipe_2, rt_out_pipe_2,
           rs_out_pipe_2, wb_regWrite, wb_rd, wb_data,
    output alu_result_out_pipe_3, write_data_out_pipe_3, branch_target_out_pipe_3,
           dest_out_pipe_3, regWrite_out_pipe_3, memtoReg_out_pipe_3, memRead_out_pipe_3,
           memWrite_out_pipe_3, branch_taken_out_pipe_3, zero_out_pipe_3
  );
endinterface

// File: rtl/ex_alu.sv
// ALU control decode plus combinational 16-bit ALU producing result and zero flag.
// Purely combinational; ADD/SUB wrap, SLT is signed and yields 1 or 0.
module ex_alu
  import mips_pkg::*;
(
  input  logic [1:0]    i_alu_op,
  input  logic [2:0]    i_funct,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_result,
  output logic          o_zero
);
  alu_op_e w_op;

  always_comb begin
    w_op     = decode_alu(i_alu_op, i_funct);
    o_result = i_a + i_b;
    case (w_op)
      ALU_SUB: o_result = i_a - i_b;
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_SLT: o_result = ($signed(i_a) < $signed(i_b)) ? {{(DW-1){1'b0}}, 1'b1} : '0;
      ALU_NOR: o_result = ~(i_a | i_b);
      default: o_result = i_a + i_b;
    endcase
  end

  assign o_zero = (o_result == '0);
endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage plus falling-edge EX/MEM register, 1 clk latency; en low holds, flush kills control.
// EX_FWD_EN defined: operands forwarded from EX/MEM then MEM/WB; undefined: raw register-file operands.
module ex_mem_stage
  import mips_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  ex_mem_stage_if.slave bus
);
  logic [DW-1:0] w_fwd_a;
  logic [DW-1:0] w_fwd_b;
  logic [DW-1:0] w_opb;
  logic [DW-1:0] w_result;
  logic          w_zero;
  logic [RW-1:0] w_dest;
  logic [DW-1:0] w_target;

  logic [DW-1:0] r_alu_result;
  logic [DW-1:0] r_write_data;
  logic [DW-1:0] r_branch_target;
  logic [RW-1:0] r_dest;
  logic          r_regWrite;
  logic          r_memtoReg;
  logic          r_memRead;
  logic          r_memWrite;
  logic          r_branch_taken;
  logic          r_zero;

`ifdef EX_FWD_EN
  // A load in EX/MEM has no data yet; the hazard unit stalls so MEM/WB supplies it.
  always_comb begin
    w_fwd_a = bus.read_data_1_out_pipe_2;
    if (bus.rs_out_pipe_2 != '0 && r_regWrite && !r_memRead && r_dest == bus.rs_out_pipe_2)
      w_fwd_a = r_alu_result;
    else if (bus.rs_out_pipe_2 != '0 && bus.wb_regWrite && bus.wb_rd == bus.rs_out_pipe_2)
      w_fwd_a = bus.wb_data;
  end

  always_comb begin
    w_fwd_b = bus.read_data_2_out_pipe_2;
    if (bus.rt_out_pipe_2 != '0 && r_regWrite && !r_memRead && r_dest == bus.rt_out_pipe_2)
      w_fwd_b = r_alu_result;
    else if (bus.rt_out_pipe_2 != '0 && bus.wb_regWrite && bus.wb_rd == bus.rt_out_pipe_2)
      w_fwd_b = bus.wb_data;
  end
`else
  assign w_fwd_a = bus.read_data_1_out_pipe_2;
  assign w_fwd_b = bus.read_data_2_out_pipe_2;
`endif

  assign w_opb    = bus.aluSrc_out_pipe_2 ? bus.sign_extended_imm_out_pipe_2 : w_fwd_b;
  assign w_dest   = bus.regDst_out_pipe_2 ? bus.rd_out_pipe_2 : bus.rt_out_pipe_2;
  assign w_target = bus.pc_plus_2_out_pipe_2 + {bus.sign_extended_imm_out_pipe_2[DW-2:0], 1'b0};

  ex_alu u_alu (
    .i_alu_op (bus.aluOp_out_pipe_2),
    .i_funct  (bus.sign_extended_imm_out_pipe_2[2:0]),
    .i_a      (w_fwd_a),
    .i_b      (w_opb),
    .o_result (w_result),
    .o_zero   (w_zero)
  );

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_result    <= '0;
      r_write_data    <= '0;
      r_branch_target <= '0;
      r_dest          <= '0;
      r_regWrite      <= 1'b0;
      r_memtoReg      <= 1'b0;
      r_memRead       <= 1'b0;
      r_memWrite      <= 1'b0;
      r_branch_taken  <= 1'b0;
      r_zero          <= 1'b0;
    end else if (bus.flush || bus.en) begin
      r_alu_result    <= w_result;
      r_write_data    <= w_fwd_b;
      r_branch_target <= w_target;
      r_dest          <= w_dest;
      r_memtoReg      <= bus.memtoReg_out_pipe_2;
      r_zero          <= w_zero;
      // Flush turns the instruction into a bubble but still lets the data fields move.
      r_regWrite      <= bus.flush ? 1'b0 : bus.regWrite_out_pipe_2;
      r_memRead       <= bus.flush ? 1'b0 : bus.memRead_out_pipe_2;
      r_memWrite      <= bus.flush ? 1'b0 : bus.memWrite_out_pipe_2;
      r_branch_taken  <= bus.flush ? 1'b0 : (bus.branch_out_pipe_2 && w_zero);
    end
  end

  assign bus.alu_result_out_pipe_3    = r_alu_result;
  assign bus.write_data_out_pipe_3    = r_write_data;
  assign bus.branch_target_out_pipe_3 = r_branch_target;
  assign bus.dest_out_pipe_3          = r_dest;
  assign bus.regWrite_out_pipe_3      = r_regWrite;
  assign bus.memtoReg_out_pipe_3      = r_memtoReg;
  assign bus.memRead_out_pipe_3       = r_memRead;
  assign bus.memWrite_out_pipe_3      = r_memWrite;
  assign bus.branch_taken_out_pipe_3  = r_branch_taken;
  assign bus.zero_out_pipe_3          = r_zero;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus randomized traffic against an instruction-level model.
// Inputs change and outputs are sampled on the rising edge; the DUT captures on the falling edge.
module tb_ex_mem_stage;
  import mips_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  ex_mem_stage_if ifc ();

  ex_mem_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Expected EX/MEM contents
  logic [15:0] m_alu, m_wd, m_bt;
  logic [2:0]  m_dest;
  logic        m_rw, m_mtr, m_mr, m_mw, m_taken, m_zero;

  task automatic model_reset();
    m_alu = 0; m_wd = 0; m_bt = 0; m_dest = 0;
    m_rw = 0; m_mtr = 0; m_mr = 0; m_mw = 0; m_taken = 0; m_zero = 0;
  endtask

  function automatic logic [15:0] operand(input logic [2:0] idx, input logic [15:0] rf);
`ifdef EX_FWD_EN
    if (idx != 0 && m_rw && !m_mr && m_dest == idx) return m_alu;
    if (idx != 0 && ifc.wb_regWrite && ifc.wb_rd == idx) return ifc.wb_data;
`endif
    return rf;
  endfunction

  // Next EX/MEM state for the instruction currently presented, given the present model state.
  task automatic model_step();
    logic [15:0] a, b, ob, res;
    if (!ifc.flush && !ifc.en) return;
    a  = operand(ifc.rs_out_pipe_2, ifc.read_data_1_out_pipe_2);
    b  = operand(ifc.rt_out_pipe_2, ifc.read_data_2_out_pipe_2);
    ob = ifc.aluSrc_out_pipe_2 ? ifc.sign_extended_imm_out_pipe_2 : b;
    case (ifc.aluOp_out_pipe_2)
      2'd0: res = a + ob;
      2'd1: res = a - ob;
      2'd3: res = a | ob;
      default: begin
        case (ifc.sign_extended_imm_out_pipe_2 % 8)
          1: res = a - ob;
          2: res = a & ob;
          3: res = a | ob;
          4: res = ($signed(a) < $signed(ob)) ? 16'd1 : 16'd0;
          5: res = ~(a | ob);
          default: res = a + ob;
        endcase
      end
    endcase
    m_alu   = res;
    m_wd    = b;
    m_bt    = 16'((32'(ifc.pc_plus_2_out_pipe_2) + 2 * 32'(ifc.sign_extended_imm_out_pipe_2)) % 65536);
    m_dest  = ifc.regDst_out_pipe_2 ? ifc.rd_out_pipe_2 : ifc.rt_out_pipe_2;
    m_mtr   = ifc.memtoReg_out_pipe_2;
    m_zero  = (res == 0);
    m_rw    = ifc.flush ? 1'b0 : ifc.regWrite_out_pipe_2;
    m_mr    = ifc.flush ? 1'b0 : ifc.memRead_out_pipe_2;
    m_mw    = ifc.flush ? 1'b0 : ifc.memWrite_out_pipe_2;
    m_taken = ifc.flush ? 1'b0 : (ifc.branch_out_pipe_2 && res == 0);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic clear_inputs();
    ifc.en = 1; ifc.flush = 0;
    ifc.regDst_out_pipe_2 = 0; ifc.aluSrc_out_pipe_2 = 0; ifc.memtoReg_out_pipe_2 = 0;
    ifc.regWrite_out_pipe_2 = 0; ifc.memRead_out_pipe_2 = 0; ifc.memWrite_out_pipe_2 = 0;
    ifc.branch_out_pipe_2 = 0; ifc.aluOp_out_pipe_2 = 0;
    ifc.sign_extended_imm_out_pipe_2 = 0; ifc.read_data_1_out_pipe_2 = 0;
    ifc.read_data_2_out_pipe_2 = 0; ifc.pc_plus_2_out_pipe_2 = 0;
    ifc.rd_out_pipe_2 = 0; ifc.rt_out_pipe_2 = 0; ifc.rs_out_pipe_2 = 0;
    ifc.wb_regWrite = 0; ifc.wb_rd = 0; ifc.wb_data = 0;
  endtask

  function automatic logic [56:0] all_outs();
    return {ifc.alu_result_out_pipe_3, ifc.write_data_out_pipe_3, ifc.branch_target_out_pipe_3,
            ifc.dest_out_pipe_3, ifc.regWrite_out_pipe_3, ifc.memtoReg_out_pipe_3,
            ifc.memRead_out_pipe_3, ifc.memWrite_out_pipe_3, ifc.branch_taken_out_pipe_3,
            ifc.zero_out_pipe_3};
  endfunction

  task automatic test_reset(input string tag);
    logic [56:0] o;
    @(posedge clk);
    #2 rst_n = 0;
    #1 o = all_outs();
    checks++;
    if (o !== 57'd0) begin errors++; $display("FAIL %s async clear: got %h want 0", tag, o); end
    @(negedge clk);
    #1 o = all_outs();
    checks++;
    if (o !== 57'd0) begin errors++; $display("FAIL %s reset hold: got %h want 0", tag, o); end
    @(posedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_rtype();
    clear_inputs();
    ifc.aluOp_out_pipe_2 = ALUOP_RTYPE; ifc.sign_extended_imm_out_pipe_2 = 16'h0001;
    ifc.read_data_1_out_pipe_2 = 16'h0005; ifc.read_data_2_out_pipe_2 = 16'h0007;
    ifc.regDst_out_pipe_2 = 1; ifc.rd_out_pipe_2 = 3; ifc.rt_out_pipe_2 = 0;
    tick();
    checks++;
    if (ifc.alu_result_out_pipe_3 !== 16'hFFFE) begin errors++; $display("FAIL rtype_sub: got %h want fffe", ifc.alu_result_out_pipe_3); end
    checks++;
    if (ifc.dest_out_pipe_3 !== 3'd3) begin errors++; $display("FAIL rtype_dest: got %0d want 3", ifc.dest_out_pipe_3); end
    checks++;
    if (ifc.zero_out_pipe_3 !== 1'b0) begin errors++; $display("FAIL rtype_zero: got %b want 0", ifc.zero_out_pipe_3); end
    ifc.sign_extended_imm_out_pipe_2 = 16'h0004;
    tick();
    checks++;
    if (ifc.alu_result_out_pipe_3 !== 16'h0001) begin errors++; $display("FAIL rtype_slt: got %h want 0001", ifc.alu_result_out_pipe_3); end
  endtask

  task automatic test_fwd_exmem();
    logic [15:0] exp;
    clear_inputs();
    ifc.aluSrc_out_pipe_2 = 1; ifc.sign_extended_imm_out_pipe_2 = 16'h1234;
    ifc.rt_out_pipe_2 = 2; ifc.regWrite_out_pipe_2 = 1;
    tick();
    ifc.rs_out_pipe_2 = 2; ifc.read_data_1_out_pipe_2 = 0; ifc.sign_extended_imm_out_pipe_2 = 16'h0001;
    ifc.rt_out_pipe_2 = 5;
    tick();
`ifdef EX_FWD_EN
    exp = 16'h1235;
`else
    exp = 16'h0001;
`endif
    checks++;
    if (ifc.alu_result_out_pipe_3 !== exp) begin errors++; $display("FAIL fwd_exmem: got %h want %h", ifc.alu_result_out_pipe_3, exp); end
  endtask

  // Set up EX/MEM writing R<dst> with val (optionally as a load), then read R<rd_idx> with MEM/WB also writing 0x00BB.
  task automatic prio_case(input string tag, input logic [2:0] dst, input logic ld,
                           input logic [15:0] fwd_exp);
    logic [15:0] exp;
    clear_inputs();
    ifc.aluSrc_out_pipe_2 = 1; ifc.sign_extended_imm_out_pipe_2 = 16'h00AA;
    ifc.rt_out_pipe_2 = dst; ifc.regWrite_out_pipe_2 = 1; ifc.memRead_out_pipe_2 = ld;
    tick();
    clear_inputs();
    ifc.rs_out_pipe_2 = dst; ifc.read_data_1_out_pipe_2 = 16'h0077; ifc.aluSrc_out_pipe_2 = 1;
    ifc.wb_regWrite = 1; ifc.wb_rd = dst; ifc.wb_data = 16'h00BB;
    tick();
`ifdef EX_FWD_EN
    exp = fwd_exp;
`else
    exp = 16'h0077;
`endif
    checks++;
    if (ifc.alu_result_out_pipe_3 !== exp) begin errors++; $display("FAIL %s: got %h want %h", tag, ifc.alu_result_out_pipe_3, exp); end
  endtask

  task automatic test_fwd_priority();
    prio_case("fwd_exmem_wins", 3'd4, 1'b0, 16'h00AA);
    prio_case("fwd_load_skips", 3'd4, 1'b1, 16'h00BB);
    prio_case("fwd_r0_never",   3'd0, 1'b0, 16'h0077);
  endtask

  task automatic test_branch();
    clear_inputs();
    ifc.branch_out_pipe_2 = 1; ifc.aluOp_out_pipe_2 = ALUOP_SUB;
    ifc.read_data_1_out_pipe_2 = 16'h0010; ifc.read_data_2_out_pipe_2 = 16'h0010;
    ifc.pc_plus_2_out_pipe_2 = 16'hFFFE; ifc.sign_extended_imm_out_pipe_2 = 16'h0002;
    tick();
    checks++;
    if (ifc.branch_taken_out_pipe_3 !== 1'b1) begin errors++; $display("FAIL branch_taken: got %b want 1", ifc.branch_taken_out_pipe_3); end
    checks++;
    if (ifc.branch_target_out_pipe_3 !== 16'h0002) begin errors++; $display("FAIL branch_target: got %h want 0002", ifc.branch_target_out_pipe_3); end
    checks++;
    if (ifc.zero_out_pipe_3 !== 1'b1) begin errors++; $display("FAIL branch_zero: got %b want 1", ifc.zero_out_pipe_3); end
  endtask

  task automatic test_stall_flush();
    // Follows test_branch: outputs hold the taken branch while stalled.
    clear_inputs();
    ifc.en = 0; ifc.regWrite_out_pipe_2 = 1; ifc.read_data_1_out_pipe_2 = 16'h4321;
    ifc.pc_plus_2_out_pipe_2 = 16'h0100;
    tick();
    checks++;
    if (ifc.branch_taken_out_pipe_3 !== 1'b1 || ifc.branch_target_out_pipe_3 !== 16'h0002 || ifc.regWrite_out_pipe_3 !== 1'b0)
      begin errors++; $display("FAIL stall_hold: got taken=%b tgt=%h rw=%b want 1 0002 0", ifc.branch_taken_out_pipe_3, ifc.branch_target_out_pipe_3, ifc.regWrite_out_pipe_3); end
    checks++;
    if (ifc.alu_result_out_pipe_3 !== 16'h0000) begin errors++; $display("FAIL stall_alu: got %h want 0000", ifc.alu_result_out_pipe_3); end
    clear_inputs();
    ifc.en = 0; ifc.flush = 1; ifc.memWrite_out_pipe_2 = 1; ifc.regWrite_out_pipe_2 = 1;
    ifc.aluSrc_out_pipe_2 = 1; ifc.read_data_1_out_pipe_2 = 16'h0100; ifc.sign_extended_imm_out_pipe_2 = 16'h0004;
    ifc.read_data_2_out_pipe_2 = 16'hABCD;
    tick();
    checks++;
    if (ifc.memWrite_out_pipe_3 !== 1'b0 || ifc.regWrite_out_pipe_3 !== 1'b0 || ifc.branch_taken_out_pipe_3 !== 1'b0)
      begin errors++; $display("FAIL flush_ctrl: got mw=%b rw=%b taken=%b want 0 0 0", ifc.memWrite_out_pipe_3, ifc.regWrite_out_pipe_3, ifc.branch_taken_out_pipe_3); end
    checks++;
    if (ifc.alu_result_out_pipe_3 !== 16'h0104 || ifc.write_data_out_pipe_3 !== 16'hABCD)
      begin errors++; $display("FAIL flush_data: got alu=%h wd=%h want 0104 abcd", ifc.alu_result_out_pipe_3, ifc.write_data_out_pipe_3); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      ifc.en = ($urandom_range(0, 7) != 0); ifc.flush = ($urandom_range(0, 9) == 0);
      ifc.regDst_out_pipe_2 = 1'($urandom); ifc.aluSrc_out_pipe_2 = 1'($urandom);
      ifc.memtoReg_out_pipe_2 = 1'($urandom); ifc.regWrite_out_pipe_2 = 1'($urandom);
      ifc.memRead_out_pipe_2 = 1'($urandom); ifc.memWrite_out_pipe_2 = 1'($urandom);
      ifc.branch_out_pipe_2 = 1'($urandom); ifc.aluOp_out_pipe_2 = 2'($urandom);
      ifc.sign_extended_imm_out_pipe_2 = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
      ifc.read_data_1_out_pipe_2 = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      ifc.read_data_2_out_pipe_2 = ($urandom_range(0, 3) == 0) ? ifc.read_data_1_out_pipe_2 : 16'($urandom);
      ifc.pc_plus_2_out_pipe_2 = 16'($urandom);
      ifc.rd_out_pipe_2 = 3'($urandom_range(0, 3)); ifc.rt_out_pipe_2 = 3'($urandom_range(0, 3));
      ifc.rs_out_pipe_2 = 3'($urandom_range(0, 3));
      ifc.wb_regWrite = 1'($urandom); ifc.wb_rd = 3'($urandom_range(0, 3)); ifc.wb_data = 16'($urandom);
      tick();
      checks++;
      if (ifc.alu_result_out_pipe_3 !== m_alu) begin errors++; $display("FAIL rnd_alu[%0d]: got %h want %h", n, ifc.alu_result_out_pipe_3, m_alu); end
      checks++;
      if (ifc.write_data_out_pipe_3 !== m_wd) begin errors++; $display("FAIL rnd_wdata[%0d]: got %h want %h", n, ifc.write_data_out_pipe_3, m_wd); end
      checks++;
      if (ifc.branch_target_out_pipe_3 !== m_bt) begin errors++; $display("FAIL rnd_target[%0d]: got %h want %h", n, ifc.branch_target_out_pipe_3, m_bt); end
      checks++;
      if (ifc.dest_out_pipe_3 !== m_dest) begin errors++; $display("FAIL rnd_dest[%0d]: got %0d want %0d", n, ifc.dest_out_pipe_3, m_dest); end
      checks++;
      if ({ifc.regWrite_out_pipe_3, ifc.memtoReg_out_pipe_3, ifc.memRead_out_pipe_3, ifc.memWrite_out_pipe_3,
           ifc.branch_taken_out_pipe_3, ifc.zero_out_pipe_3} !== {m_rw, m_mtr, m_mr, m_mw, m_taken, m_zero})
        begin errors++; $display("FAIL rnd_ctrl[%0d]: got %b%b%b%b%b%b want %b%b%b%b%b%b", n,
          ifc.regWrite_out_pipe_3, ifc.memtoReg_out_pipe_3, ifc.memRead_out_pipe_3, ifc.memWrite_out_pipe_3,
          ifc.branch_taken_out_pipe_3, ifc.zero_out_pipe_3, m_rw, m_mtr, m_mr, m_mw, m_taken, m_zero); end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    model_reset();
    clear_inputs();
    rst_n = 0;
    #3 rst_n = 1;
    // Load something nonzero so the reset check has bits to clear.
    ifc.read_data_1_out_pipe_2 = 16'h0F0F; ifc.read_data_2_out_pipe_2 = 16'h1111;
    ifc.regWrite_out_pipe_2 = 1; ifc.memWrite_out_pipe_2 = 1; ifc.rt_out_pipe_2 = 5;
    ifc.pc_plus_2_out_pipe_2 = 16'h0040;
    tick();
    test_reset("reset");
    test_rtype();
    test_fwd_exmem();
    test_fwd_priority();
    test_branch();
    test_stall_flush();
    test_branch();
    ifc.en = 0;
    test_reset("reset_mid_branch");
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute stage and EX/MEM pipeline register of the 16-bit pipelined MIPS core. It consumes the `*_out_pipe_2` bundle from the ID/EX register and selects forwarded operands. It computes the ALU result, branch decision and branch target, then registers everything into the `*_out_pipe_3` bundle consumed by the MEM stage, the forwarding logic and the IF flush logic.

## Interface
- `DW`, 16, datapath width
- `RW`, 3, register-index width
- `clk` in 1 — stage clock; the register captures on the falling edge, like the other pipeline registers.
- `rst_n` in 1 — asynchronous, active-low reset.
- `en` in 1 — stage enable; hold the register when low (stall).
- `flush` in 1 — squash the instruction entering EX/MEM.
- `regDst_out_pipe_2`, `aluSrc_out_pipe_2`, `memtoReg_out_pipe_2`, `regWrite_out_pipe_2`, `memRead_out_pipe_2`, `memWrite_out_pipe_2`, `branch_out_pipe_2` in 1 each — ID/EX control.
- `aluOp_out_pipe_2` in 2 — ALU class.
- `sign_extended_imm_out_pipe_2`, `read_data_1_out_pipe_2`, `read_data_2_out_pipe_2`, `pc_plus_2_out_pipe_2` in DW — ID/EX data.
- `rd_out_pipe_2`, `rt_out_pipe_2` in RW — destination candidates.
- `rs_out_pipe_2` in RW — source A index, for forwarding.
- `wb_regWrite` in 1, `wb_rd` in RW, `wb_data` in DW — MEM/WB write-back bundle.
- `alu_result_out_pipe_3`, `write_data_out_pipe_3`, `branch_target_out_pipe_3` out DW — registered data.
- `dest_out_pipe_3` out RW — registered destination register.
- `regWrite_out_pipe_3`, `memtoReg_out_pipe_3`, `memRead_out_pipe_3`, `memWrite_out_pipe_3`, `branch_taken_out_pipe_3`, `zero_out_pipe_3` out 1 — registered control and flags.

## Operation
- **Destination:** `regDst` ? `rd` : `rt`.
- **Forwarding**, per operand A (`rs`) and B (`rt`). Priority order:
  - EX/MEM: when `regWrite_out_pipe_3 && !memRead_out_pipe_3 && dest_out_pipe_3 == idx` → use `alu_result_out_pipe_3`.
  - Otherwise MEM/WB: when `wb_regWrite && wb_rd == idx` → use `wb_data`.
  - Otherwise use the register-file value.
  - Index 0 is never forwarded; R0 reads the register-file value.
  - A load sitting in EX/MEM is not forwarded from EX/MEM. The hazard unit stalls, and the data arrives next cycle via MEM/WB.
- **Operand B:** `aluSrc` ? immediate : forwarded B.
- **Store data:** `write_data` is always forwarded B.
- **ALU control:**
  - `aluOp` 00 → ADD; 01 → SUB; 11 → OR.
  - `aluOp` 10 decodes funct = `imm[2:0]`: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT (signed), 101 NOR.
  - Undefined funct codes → ADD.
- **Arithmetic:** ADD and SUB wrap modulo 2^16; no overflow trap. SLT yields 16'h0001 or 16'h0000.
- **Flags and branch:**
  - `zero` = (result == 0).
  - `branch_taken` = `branch && zero`.
  - Branch target = `pc_plus_2 + (imm << 1)`, truncated to 16 bits (wraps).
- **Register update priority:** `rst_n` low > `flush` > `en`.
  - `flush`, regardless of `en`: clear `regWrite`, `memRead`, `memWrite` and `branch_taken`; data fields load normally.
  - `en` low with no flush: every output holds.

## Timing
- Combinational EX path, then one falling-edge capture. Latency is 1 clk from ID/EX output to `*_out_pipe_3`.
- Reset value of every output is 0, applied immediately on `rst_n` falling. Reset mid-stall or mid-branch also clears all outputs.
- EX/MEM forwarding uses the current register outputs. Back-to-back dependent ALU ops therefore need no stall.
- When EX/MEM and MEM/WB both match the same index, EX/MEM wins.
- A taken branch is visible on `branch_taken_out_pipe_3` one edge after EX. The upstream flush of IF/ID and ID/EX is owned by the control unit.

## Configuration
- `EX_FWD_EN`:
  - Defined: forwarding muxes as above.
  - Undefined: operands come straight from `read_data_1/2_out_pipe_2`, and the `wb_*` and `rs` inputs are unused. Software or the hazard unit must insert bubbles.

## Structure
- Shared package `mips_pkg`:
  - `DW` and `RW`.
  - `aluOp` encodings (`ALUOP_ADD`, `ALUOP_SUB`, `ALUOP_RTYPE`, `ALUOP_OR`).
  - funct codes.
  - internal ALU-operation enum.
- One sub-module, `ex_alu`: ALU control decode plus the combinational ALU producing result and `zero`. Forwarding and the register stay in `ex_mem_stage`.

## Test plan
- **Reset:** drive nonzero inputs, pulse `rst_n` low → all outputs 0 asynchronously; hold until release.
- **R-type:** `aluOp`=10, funct=001, A=16'h0005, B=16'h0007, `regDst`=1, `rd`=3 → result 16'hFFFE, `dest`=3, `zero`=0. Funct=100 with the same operands → result 16'h0001.
- **EX/MEM forwarding:** ADD writes R2 = 16'h1234; next instruction reads `rs`=2 with a stale regfile value of 0 and imm 1 → result 16'h1235. With `EX_FWD_EN` undefined → result 16'h0001.
- **Forwarding priority and R0:** EX/MEM and MEM/WB both target R4 with 16'h00AA and 16'h00BB → A = 16'h00AA. Load in EX/MEM targeting R4 → A = 16'h00BB. Any forward targeting R0 → regfile value used.
- **Branch:** `branch`=1, `aluOp`=01, A=B=16'h0010, PC+2=16'hFFFE, imm=2 → `branch_taken`=1, target 16'h0002 (wraps).
- **Stall and flush:** `en`=0 → outputs hold. Then `flush`=1 with `en`=0 on a store → `memWrite`=0 and `regWrite`=0 after the edge.
